// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch front end. It issues one-cycle read requests to
// instruction memory and waits for the response. It then holds the returned
// word for the decode stage until decode accepts it. After an accept it moves
// the PC to PC+4 or to a taken branch target. A flush restarts fetching from
// a new address at any time.
//
// Parameters:
//   RESET_PC      PC loaded on reset (word aligned)
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rstN          asynchronous active-low reset
//   imemReq       one-cycle memory read request
//   imemAddr      request byte address (the PC register)
//   imemRvalid    memory read data valid (only looked at while waiting)
//   imemRdata     memory read data
//   instrValid    held instruction is valid for decode
//   instrReady    decode accepts the held instruction
//   instr         held instruction word
//   opCode        instr[6:0] for the control unit
//   pcOut         PC of the held instruction
//   branchTaken   redirect on accept
//   branchTarget  branch redirect address
//   flush         redirect that overrides everything else
//   flushPc       flush restart address
//   misalignErr   one-cycle pulse after loading a misaligned redirect
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstN,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instr,
  output logic [6:0]  opCode,
  output logic [31:0] pcOut,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        flush,
  input  logic [31:0] flushPc,
  output logic        misalignErr
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        drop_q, drop_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;

  logic        redirect;
  logic [31:0] redirect_addr;

  // Next-state logic. Every redirect (flush or taken branch) goes through
  // one path. That path forces word alignment and flags misaligned
  // addresses. The registered outputs come from the next state, so
  // imemReq and instrValid appear in the same cycle as the state they
  // belong to.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    drop_d        = drop_q;
    misalign_d    = 1'b0;
    redirect      = 1'b0;
    redirect_addr = flushPc;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (flush) begin
          redirect = 1'b1;
        end
      end

      // The request goes out in this cycle. Any response that shows up now
      // belongs to nothing we are waiting for, so it is ignored.
      REQ: begin
        if (flush) begin
          redirect = 1'b1;
          state_d  = REQ;
        end else begin
          state_d = WAIT;
        end
      end

      // A flush while a request is outstanding cannot cancel the memory
      // access. We remember to throw away the response unless it arrives
      // in this same cycle.
      WAIT: begin
        if (flush) begin
          redirect = 1'b1;
          if (imemRvalid) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imemRvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d  = imemRdata;
            pc_out_d = pc_q;
            state_d  = HOLD;
          end
        end
      end

      HOLD: begin
        if (flush) begin
          redirect = 1'b1;
          state_d  = REQ;
        end else if (instrReady) begin
          state_d = REQ;
          if (branchTaken) begin
            redirect      = 1'b1;
            redirect_addr = branchTarget;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (redirect) begin
      pc_d       = {redirect_addr[31:2], 2'b00};
      misalign_d = |redirect_addr[1:0];
    end
  end

  assign req_d   = (state_d == REQ);
  assign valid_d = (state_d == HOLD);

  // State and output registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      pc_out_q   <= RESET_PC;
      drop_q     <= 1'b0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      drop_q     <= drop_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign imemReq     = req_q;
  assign imemAddr    = pc_q;
  assign instrValid  = valid_q;
  assign instr       = instr_q;
  assign opCode      = instr_q[6:0];
  assign pcOut       = pc_out_q;
  assign misalignErr = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. It has three parts:
//   1. A table of single-cycle vectors that walks through the fetch,
//      stall, branch, wrap and flush corner cases.
//   2. An asynchronous reset asserted in the middle of a memory wait.
//   3. A randomized run. A memory model answers requests with random
//      latency, and a transaction-level reference checks the fetch
//      address stream, the presented instructions and the misalign pulses.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rstN;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [6:0]  opCode;
  logic [31:0] pcOut;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        flush;
  logic [31:0] flushPc;
  logic        misalignErr;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        br;
    logic [31:0] tgt;
    logic        fl;
    logic [31:0] fpc;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] eInstr;
    logic [31:0] ePc;
    logic        eMis;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemRvalid   (imemRvalid),
    .imemRdata    (imemRdata),
    .instrValid   (instrValid),
    .instrReady   (instrReady),
    .instr        (instr),
    .opCode       (opCode),
    .pcOut        (pcOut),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .flush        (flush),
    .flushPc      (flushPc),
    .misalignErr  (misalignErr)
  );

  // Contents of the modelled instruction memory: a fixed scramble of the
  // address, so the word presented can be traced back to its address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic vec_t mk(input string n, input logic rv, input logic [31:0] rd,
                              input logic rdy, input logic br, input logic [31:0] tgt,
                              input logic fl, input logic [31:0] fpc,
                              input logic eReq, input logic [31:0] eAddr,
                              input logic eValid, input logic [31:0] eInstr,
                              input logic [31:0] ePc, input logic eMis);
    vec_t v;
    v.name = n;   v.rvalid = rv;   v.rdata = rd;   v.ready = rdy;
    v.br = br;    v.tgt = tgt;     v.fl = fl;      v.fpc = fpc;
    v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid;
    v.eInstr = eInstr; v.ePc = ePc; v.eMis = eMis;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rstN         = 1'b1;
    imemRvalid   = v.rvalid;
    imemRdata    = v.rdata;
    instrReady   = v.ready;
    branchTaken  = v.br;
    branchTarget = v.tgt;
    flush        = v.fl;
    flushPc      = v.fpc;
  endtask

  task automatic clearInputs();
    imemRvalid   = 1'b0;
    imemRdata    = 32'h0;
    instrReady   = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = 32'h0;
    flush        = 1'b0;
    flushPc      = 32'h0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_imemReq"},     32'(imemReq),     32'h0);
    checkOutput({tag, "_imemAddr"},    imemAddr,         32'h0);
    checkOutput({tag, "_instrValid"},  32'(instrValid),  32'h0);
    checkOutput({tag, "_instr"},       instr,            32'h0000_0013);
    checkOutput({tag, "_opCode"},      32'(opCode),      32'h13);
    checkOutput({tag, "_pcOut"},       pcOut,            32'h0);
    checkOutput({tag, "_misalignErr"}, 32'(misalignErr), 32'h0);
  endtask

  // Apply each queued vector at a falling edge and check the outputs just
  // after the following rising edge. Data outputs are only meaningful while
  // the instruction is valid.
  task automatic runVectors();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput({vecs[i].name, "_imemReq"},     32'(imemReq),     32'(vecs[i].eReq));
      checkOutput({vecs[i].name, "_imemAddr"},    imemAddr,         vecs[i].eAddr);
      checkOutput({vecs[i].name, "_instrValid"},  32'(instrValid),  32'(vecs[i].eValid));
      checkOutput({vecs[i].name, "_misalignErr"}, 32'(misalignErr), 32'(vecs[i].eMis));
      if (vecs[i].eValid) begin
        checkOutput({vecs[i].name, "_instr"},  instr,        vecs[i].eInstr);
        checkOutput({vecs[i].name, "_opCode"}, 32'(opCode),  32'(vecs[i].eInstr[6:0]));
        checkOutput({vecs[i].name, "_pcOut"},  pcOut,        vecs[i].ePc);
      end
      @(negedge clk);
    end
    vecs.delete();
  endtask

  // Hard time limit so the bench can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "[TB] time limit exceeded");
  end

  initial begin
    logic [31:0] expNext, lastReqAddr, heldInstr, heldPc, tmpWord;
    logic [31:0] pendAddr, fpc, tgt;
    logic        flushedSinceReq, expMis, prevValid, prevAccept, prevFlush;
    logic        pending, rdy, br, fl, accept;
    int          cnt, idle, fetched;

    rstN = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset");
    @(negedge clk);

    // Fetch, stall, branch, wrap and flush sequence.
    vecs.push_back(mk("rel_req",      0, 32'h0,         1, 0, 32'h0,         0, 32'h0,   1, 32'h0,         0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("req_ign_rv",   1, 32'hDEAD_BEEF, 1, 0, 32'h0,         0, 32'h0,   0, 32'h0,         0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("fetch_0",      1, 32'h0000_0033, 1, 0, 32'h0,         0, 32'h0,   0, 32'h0,         1, 32'h0000_0033, 32'h0,         0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk("hold_stall", 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,   0, 32'h0,         1, 32'h0000_0033, 32'h0,         0));
    vecs.push_back(mk("accept_seq",   0, 32'h0,         1, 0, 32'h0,         0, 32'h0,   1, 32'h4,         0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("wait_4",       0, 32'h0,         1, 0, 32'h0,         0, 32'h0,   0, 32'h4,         0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("fetch_4",      1, 32'h0040_0093, 1, 0, 32'h0,         0, 32'h0,   0, 32'h4,         1, 32'h0040_0093, 32'h4,         0));
    vecs.push_back(mk("br_misalign",  0, 32'h0,         1, 1, 32'h0000_0102, 0, 32'h0,   1, 32'h100,       0, 32'h0,         32'h0,         1));
    vecs.push_back(mk("wait_100",     0, 32'h0,         1, 1, 32'h0000_0777, 0, 32'h0,   0, 32'h100,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("fetch_100",    1, 32'h0000_0063, 1, 0, 32'h0,         0, 32'h0,   0, 32'h100,       1, 32'h0000_0063, 32'h100,       0));
    vecs.push_back(mk("br_top",       0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0,   1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("wait_top",     0, 32'h0,         1, 0, 32'h0,         0, 32'h0,   0, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("fetch_top",    1, 32'h0000_0037, 1, 0, 32'h0,         0, 32'h0,   0, 32'hFFFF_FFFC, 1, 32'h0000_0037, 32'hFFFF_FFFC, 0));
    vecs.push_back(mk("pc_wrap",      0, 32'h0,         1, 0, 32'h0,         0, 32'h0,   1, 32'h0,         0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("flush_req",    0, 32'h0,         1, 0, 32'h0,         1, 32'h301, 1, 32'h300,       0, 32'h0,         32'h0,         1));
    vecs.push_back(mk("wait_300",     0, 32'h0,         1, 0, 32'h0,         0, 32'h0,   0, 32'h300,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("flush_wait",   0, 32'h0,         1, 0, 32'h0,         1, 32'h200, 0, 32'h200,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("drop_wait1",   0, 32'h0,         1, 0, 32'h0,         0, 32'h0,   0, 32'h200,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("drop_wait2",   0, 32'h0,         1, 0, 32'h0,         0, 32'h0,   0, 32'h200,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("stale_drop",   1, 32'h0BAD_0033, 1, 0, 32'h0,         0, 32'h0,   1, 32'h200,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("wait_200",     0, 32'h0,         1, 0, 32'h0,         0, 32'h0,   0, 32'h200,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("fetch_200",    1, 32'h0000_1013, 1, 0, 32'h0,         0, 32'h0,   0, 32'h200,       1, 32'h0000_1013, 32'h200,       0));
    vecs.push_back(mk("flush_hold",   0, 32'h0,         1, 1, 32'h0000_0800, 1, 32'h400, 1, 32'h400,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("wait_400",     0, 32'h0,         1, 0, 32'h0,         0, 32'h0,   0, 32'h400,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("flush_rvalid", 1, 32'hFFFF_FFFF, 1, 0, 32'h0,         1, 32'h500, 1, 32'h500,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("wait_500",     0, 32'h0,         1, 0, 32'h0,         0, 32'h0,   0, 32'h500,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("fetch_500",    1, 32'h0000_2023, 1, 0, 32'h0,         0, 32'h0,   0, 32'h500,       1, 32'h0000_2023, 32'h500,       0));
    vecs.push_back(mk("accept_500",   0, 32'h0,         1, 0, 32'h0,         0, 32'h0,   1, 32'h504,       0, 32'h0,         32'h0,         0));
    vecs.push_back(mk("wait_504",     0, 32'h0,         1, 0, 32'h0,         0, 32'h0,   0, 32'h504,       0, 32'h0,         32'h0,         0));
    runVectors();

    // Reset pulled in the middle of a wait: outputs must fall back at once,
    // and a late response after release must not be taken.
    #2;
    rstN = 1'b0;
    #1;
    checkReset("async_reset");
    @(negedge clk);
    vecs.push_back(mk("late_rv_idle", 1, 32'hDEAD_0033, 1, 0, 32'h0, 0, 32'h0, 1, 32'h0, 0, 32'h0,         32'h0, 0));
    vecs.push_back(mk("late_rv_req",  1, 32'hDEAD_0033, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0,         32'h0, 0));
    vecs.push_back(mk("refetch_0",    1, 32'h0000_0093, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'h0000_0093, 32'h0, 0));
    vecs.push_back(mk("refetch_acc",  0, 32'h0,         1, 0, 32'h0, 0, 32'h0, 1, 32'h4, 0, 32'h0,         32'h0, 0));
    runVectors();

    // Randomized run against the transaction-level reference.
    rstN = 1'b0;
    clearInputs();
    @(negedge clk);
    rstN = 1'b1;
    expNext = 32'h0;  lastReqAddr = 32'h0;  heldInstr = 32'h0;  heldPc = 32'h0;
    flushedSinceReq = 1'b0;  expMis = 1'b0;
    prevValid = 1'b0;  prevAccept = 1'b0;  prevFlush = 1'b0;
    pending = 1'b0;  pendAddr = 32'h0;  cnt = 0;  idle = 0;  fetched = 0;

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);

      checkOutput("rnd_misalign", 32'(misalignErr), 32'(expMis));

      if (imemReq) begin
        checkOutput("rnd_fetch_addr", imemAddr, expNext);
        checkOutput("rnd_req_while_valid", 32'(instrValid), 32'h0);
        lastReqAddr     = expNext;
        flushedSinceReq = 1'b0;
        idle            = 0;
      end else begin
        idle++;
      end

      if (prevValid && (prevAccept || prevFlush)) begin
        checkOutput("rnd_valid_drop", 32'(instrValid), 32'h0);
      end else if (prevValid) begin
        checkOutput("rnd_valid_hold", 32'(instrValid), 32'h1);
        checkOutput("rnd_instr_stable", instr, heldInstr);
        checkOutput("rnd_pcout_stable", pcOut, heldPc);
      end else if (instrValid) begin
        tmpWord = memWord(lastReqAddr);
        checkOutput("rnd_stale_presented", 32'(flushedSinceReq), 32'h0);
        checkOutput("rnd_pcout", pcOut, lastReqAddr);
        checkOutput("rnd_instr", instr, tmpWord);
        checkOutput("rnd_opcode", 32'(opCode), 32'(tmpWord[6:0]));
        heldInstr = tmpWord;
        heldPc    = lastReqAddr;
        fetched++;
      end

      if (idle > 40) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL rnd_progress: got %0d idle cycles, expected at most 40", idle);
        break;
      end

      // Memory: answer the outstanding request after its latency, and
      // throw junk valids at cycles where the fetch unit must ignore them.
      if (pending) begin
        if (cnt == 1) begin
          imemRvalid = 1'b1;
          imemRdata  = memWord(pendAddr);
          pending    = 1'b0;
        end else begin
          cnt--;
          imemRvalid = 1'b0;
          imemRdata  = $urandom;
        end
      end else begin
        imemRvalid = (imemReq || instrValid) && ($urandom_range(0, 1) == 0);
        imemRdata  = $urandom;
      end
      if (imemReq) begin
        pending  = 1'b1;
        cnt      = $urandom_range(1, 3);
        pendAddr = imemAddr;
      end

      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 2) == 0);
      tgt = $urandom;
      fl  = !imemReq && ($urandom_range(0, 9) == 0);
      fpc = $urandom;

      accept = instrValid && rdy && !fl;
      expMis = fl ? |fpc[1:0] : (accept && br && |tgt[1:0]);
      if (fl) begin
        expNext         = {fpc[31:2], 2'b00};
        flushedSinceReq = 1'b1;
      end else if (accept) begin
        expNext = br ? {tgt[31:2], 2'b00} : lastReqAddr + 32'd4;
      end
      prevValid  = instrValid;
      prevAccept = accept;
      prevFlush  = fl;

      instrReady   = rdy;
      branchTaken  = br;
      branchTarget = tgt;
      flush        = fl;
      flushPc      = fpc;
    end

    checkOutput("rnd_some_fetched", 32'(fetched > 100), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC loaded at reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-003 rstN  input  1  asynchronous, active-low reset.
REQ-004 imemReq  output  1  one-cycle instruction memory read request.
REQ-005 imemAddr  output  32  byte address of the request; SHALL equal the PC register.
REQ-006 imemRvalid  input  1  read data valid; SHALL be ignored outside WAIT.
REQ-007 imemRdata  input  32  instruction word returned by memory.
REQ-008 instrValid  output  1  the decode-side instruction is valid.
REQ-009 instrReady  input  1  the decode/control stage accepts the instruction.
REQ-010 instr  output  32  held instruction word.
REQ-011 opCode  output  7  instr[6:0], fed to the control unit.
REQ-012 pcOut  output  32  PC of the held instruction.
REQ-013 branchTaken  input  1  redirect for the next PC; sampled only on accept.
REQ-014 branchTarget  input  32  redirect address.
REQ-015 flush  input  1  asynchronous-to-pipeline redirect that overrides all else.
REQ-016 flushPc  input  32  restart address for flush.
REQ-017 misalignErr  output  1  one-cycle pulse when a redirect address has bits [1:0] non-zero.

Function
REQ-018 FSM states: IDLE, REQ, WAIT, HOLD; encoding is free.
REQ-019 IDLE: entered only from reset; the FSM SHALL go to REQ on the next edge.
REQ-020 REQ: imemReq=1 for exactly one cycle, imemAddr=PC; next state WAIT.
REQ-021 WAIT: on imemRvalid=1, capture imemRdata into instr and PC into pcOut; next state HOLD; otherwise remain in WAIT indefinitely.
REQ-022 Memory response SHALL NOT be accepted in the REQ cycle; minimum request-to-data latency is 1 cycle.
REQ-023 HOLD: instrValid=1; instr, opCode and pcOut SHALL be stable until accept.
REQ-024 Accept = instrValid && instrReady; on accept, PC <= branchTaken ? branchTarget : PC+4, and the next state is REQ.
REQ-025 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 Any redirect address (branchTarget or flushPc) SHALL have bits [1:0] forced to 0 when loaded; misalignErr SHALL pulse in the cycle after the load if the original bits were non-zero.
REQ-027 flush=1 in REQ or HOLD: PC <= flushPc, instrValid drops next cycle, next state REQ; instrReady in that cycle SHALL be ignored.
REQ-028 flush=1 in WAIT: PC <= flushPc, a drop flag is set, and the FSM stays in WAIT; the next imemRvalid SHALL be discarded and clear the flag, and the next state is REQ.
REQ-029 If imemRvalid and flush coincide in WAIT, the response SHALL be discarded, with no drop flag set, and the next state is REQ.
REQ-030 flush in IDLE SHALL load flushPc; the next state is REQ.
REQ-031 flush has priority over branchTaken in the same cycle.
REQ-032 Throughput: with zero-wait memory and instrReady=1, one instruction every 3 cycles.

Reset
REQ-033 While rstN=0: state IDLE, PC=RESET_PC, imemReq=0, instrValid=0, instr=32'h0000_0013 (NOP), pcOut=RESET_PC, misalignErr=0, drop flag=0.
REQ-034 Reset assertion mid-transaction SHALL abandon the transaction; a late imemRvalid after reset release SHALL be ignored, since the state is not WAIT.
REQ-035 The first request SHALL occur in the second cycle after rstN deasserts (IDLE, then REQ).

Verification
REQ-036 Reset release, 1-cycle memory returning 32'h0000_0033, instrReady=1 -> imemAddr=0 in cycle 2; instrValid with opCode=7'h33, pcOut=0 in cycle 4; next imemAddr=4.
REQ-037 HOLD with instrReady=0 for 5 cycles -> instr/pcOut stable, no imemReq; then ready -> PC advances by 4.
REQ-038 Accept with branchTaken=1, branchTarget=32'h0000_0102 -> next imemAddr=32'h0000_0100 and misalignErr pulses once.
REQ-039 flush in WAIT with flushPc=32'h200, stale rvalid 3 cycles later -> stale data not presented; next imemAddr=32'h200.
REQ-040 PC=32'hFFFF_FFFC accepted without branch -> next imemAddr=32'h0000_0000.
REQ-041 rstN pulsed low during WAIT -> all outputs return to reset values immediately; restart fetch from RESET_PC.
